// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI bus arbiter.
package spi_arb_pkg;
   localparam int CMD_W = 16;
   localparam logic [CMD_W-1:0] TIMEOUT_RD_DATA = 16'h0000;

   typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, RESP} state_t;
   typedef enum logic {OWN_INERT, OWN_A2D} owner_t;
endpackage

// File: rtl/spi_arb_wdog.sv
// Transaction watchdog: counts enabled cycles from a clear, flags the last allowed cycle.
module spi_arb_wdog #(
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(TIMEOUT_CYC) + 1;

   logic [W-1:0] cnt_q, cnt_d;

   assign expired_o = en_i && (cnt_q == W'(TIMEOUT_CYC - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expired_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
endmodule

// File: rtl/spi_bus_arb.sv
// Shares one SPI master between the inertial and A2D requesters; inertial has
// priority, A2D is forced through after MAX_WAIT consecutive losses.
module spi_bus_arb
   import spi_arb_pkg::*;
#(
   parameter int MAX_WAIT    = 3,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inert_req_i,
   input  logic [CMD_W-1:0] inert_cmd_i,
   output logic             inert_gnt_o,
   output logic             inert_done_o,
   output logic [CMD_W-1:0] inert_rd_o,
   input  logic             a2d_req_i,
   input  logic [CMD_W-1:0] a2d_cmd_i,
   output logic             a2d_gnt_o,
   output logic             a2d_done_o,
   output logic [CMD_W-1:0] a2d_rd_o,
   output logic             spi_wrt_o,
   output logic [CMD_W-1:0] spi_cmd_o,
   input  logic             spi_done_i,
   input  logic [CMD_W-1:0] spi_rd_data_i,
   output logic             timeout_err_o
);
   localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

   state_t           state_q, state_d;
   owner_t           owner_q, owner_d;
   logic [3:0]       skip_q, skip_d;
   logic             inert_gnt_q, inert_gnt_d, a2d_gnt_q, a2d_gnt_d;
   logic             inert_done_q, inert_done_d, a2d_done_q, a2d_done_d;
   logic [CMD_W-1:0] inert_rd_q, inert_rd_d, a2d_rd_q, a2d_rd_d;
   logic             spi_wrt_q, spi_wrt_d, tout_q, tout_d;
   logic [CMD_W-1:0] spi_cmd_q, spi_cmd_d;
   logic             a2d_win;
   logic [CMD_W-1:0] rd_v;
   logic             wd_exp;

   spi_arb_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (state_q == LAUNCH),
      .en_i     (state_q == BUSY),
      .expired_o(wd_exp)
   );

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      skip_d       = skip_q;
      inert_gnt_d  = inert_gnt_q;
      a2d_gnt_d    = a2d_gnt_q;
      inert_rd_d   = inert_rd_q;
      a2d_rd_d     = a2d_rd_q;
      spi_cmd_d    = spi_cmd_q;
      inert_done_d = 1'b0;
      a2d_done_d   = 1'b0;
      spi_wrt_d    = 1'b0;
      tout_d       = 1'b0;
      a2d_win      = a2d_req_i && (!inert_req_i || skip_q == MAX_W);
      rd_v         = spi_done_i ? spi_rd_data_i : TIMEOUT_RD_DATA;
      unique case (state_q)
         IDLE: begin
            if (inert_req_i || a2d_req_i) begin
               owner_d     = a2d_win ? OWN_A2D : OWN_INERT;
               spi_cmd_d   = a2d_win ? a2d_cmd_i : inert_cmd_i;
               inert_gnt_d = !a2d_win;
               a2d_gnt_d   = a2d_win;
               spi_wrt_d   = 1'b1;
               state_d     = LAUNCH;
               if (a2d_win)
                  skip_d = '0;
               else if (a2d_req_i && skip_q != MAX_W)
                  skip_d = skip_q + 4'd1;
            end
         end
         // spi_done during LAUNCH belongs to no transaction of ours and is dropped.
         LAUNCH: state_d = BUSY;
         BUSY: begin
            if (spi_done_i || wd_exp) begin
               tout_d  = !spi_done_i;
               state_d = RESP;
               if (owner_q == OWN_A2D) begin
                  a2d_rd_d   = rd_v;
                  a2d_done_d = 1'b1;
               end else begin
                  inert_rd_d   = rd_v;
                  inert_done_d = 1'b1;
               end
            end
         end
         RESP: begin
            inert_gnt_d = 1'b0;
            a2d_gnt_d   = 1'b0;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         owner_q      <= OWN_INERT;
         skip_q       <= '0;
         inert_gnt_q  <= 1'b0;
         a2d_gnt_q    <= 1'b0;
         inert_done_q <= 1'b0;
         a2d_done_q   <= 1'b0;
         inert_rd_q   <= '0;
         a2d_rd_q     <= '0;
         spi_wrt_q    <= 1'b0;
         spi_cmd_q    <= '0;
         tout_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         skip_q       <= skip_d;
         inert_gnt_q  <= inert_gnt_d;
         a2d_gnt_q    <= a2d_gnt_d;
         inert_done_q <= inert_done_d;
         a2d_done_q   <= a2d_done_d;
         inert_rd_q   <= inert_rd_d;
         a2d_rd_q     <= a2d_rd_d;
         spi_wrt_q    <= spi_wrt_d;
         spi_cmd_q    <= spi_cmd_d;
         tout_q       <= tout_d;
      end
   end

   assign inert_gnt_o   = inert_gnt_q;
   assign a2d_gnt_o     = a2d_gnt_q;
   assign inert_done_o  = inert_done_q;
   assign a2d_done_o    = a2d_done_q;
   assign inert_rd_o    = inert_rd_q;
   assign a2d_rd_o      = a2d_rd_q;
   assign spi_wrt_o     = spi_wrt_q;
   assign spi_cmd_o     = spi_cmd_q;
   assign timeout_err_o = tout_q;
endmodule

// File: tb/tb_spi_bus_arb.sv
// Bench for spi_bus_arb: the bench plays the SPI master and models arbitration order.
module tb_spi_bus_arb;
   localparam int MW = 3;
   localparam int TO = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic inert_req = 1'b0, a2d_req = 1'b0, spi_done = 1'b0;
   logic [15:0] inert_cmd = '0, a2d_cmd = '0, spi_rd_data = '0;
   logic inert_gnt, inert_done, a2d_gnt, a2d_done, spi_wrt, timeout_err;
   logic [15:0] inert_rd, a2d_rd, spi_cmd;

   int n_tests = 0;
   int n_fail  = 0;
   int streak  = 0;
   logic [15:0] m_inert_rd = '0, m_a2d_rd = '0;
   bit both_gnt_seen = 1'b0;

   always #5 clk = ~clk;

   spi_bus_arb #(.MAX_WAIT(MW), .TIMEOUT_CYC(TO)) dut (
      .clk_i(clk), .rst_i(rst),
      .inert_req_i(inert_req), .inert_cmd_i(inert_cmd), .inert_gnt_o(inert_gnt),
      .inert_done_o(inert_done), .inert_rd_o(inert_rd),
      .a2d_req_i(a2d_req), .a2d_cmd_i(a2d_cmd), .a2d_gnt_o(a2d_gnt),
      .a2d_done_o(a2d_done), .a2d_rd_o(a2d_rd),
      .spi_wrt_o(spi_wrt), .spi_cmd_o(spi_cmd), .spi_done_i(spi_done),
      .spi_rd_data_i(spi_rd_data), .timeout_err_o(timeout_err)
   );

   always @(negedge clk) if (inert_gnt && a2d_gnt) both_gnt_seen = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Serve one transaction starting from an IDLE cycle. k = BUSY cycles before
   // spi_done (k<0: never, watchdog fires after TO BUSY cycles).
   task automatic serve(input int k, input logic [15:0] data, input bit stale,
                        input bit drop, output bit own_a2d);
      bit exp_a, early, exp_to;
      logic [15:0] cmd, erd;
      int n;
      exp_a   = a2d_req && (!inert_req || streak == MW);
      own_a2d = exp_a;
      cmd     = exp_a ? a2d_cmd : inert_cmd;
      if (exp_a) streak = 0;
      else if (a2d_req && streak < MW) streak++;
      tick();
      n_tests++;
      if (spi_wrt !== 1'b1 || inert_gnt !== !exp_a || a2d_gnt !== exp_a || spi_cmd !== cmd) begin
         n_fail++;
         $display("FAIL launch: wrt=%b ig=%b ag=%b cmd=%h, want wrt=1 ig=%b ag=%b cmd=%h",
                  spi_wrt, inert_gnt, a2d_gnt, spi_cmd, !exp_a, exp_a, cmd);
      end
      if (stale) begin spi_done = 1'b1; spi_rd_data = 16'($urandom); end
      tick();
      spi_done = 1'b0;
      n_tests++;
      if (spi_wrt !== 1'b0 || inert_done !== 1'b0 || a2d_done !== 1'b0 ||
          inert_gnt !== !exp_a || a2d_gnt !== exp_a) begin
         n_fail++;
         $display("FAIL busy_entry: wrt=%b idone=%b adone=%b ig=%b ag=%b, want 0 0 0 %b %b",
                  spi_wrt, inert_done, a2d_done, inert_gnt, a2d_gnt, !exp_a, exp_a);
      end
      if (drop) begin
         if (exp_a) a2d_req = 1'b0; else inert_req = 1'b0;
      end
      early = 1'b0;
      n = (k < 0) ? TO - 1 : k;
      repeat (n) begin
         tick();
         if (inert_done || a2d_done || timeout_err) early = 1'b1;
      end
      if (k >= 0) begin spi_done = 1'b1; spi_rd_data = data; end
      tick();
      spi_done = 1'b0;
      exp_to = (k < 0);
      erd = exp_to ? 16'h0000 : data;
      if (exp_a) m_a2d_rd = erd; else m_inert_rd = erd;
      n_tests++;
      if (early || inert_done !== !exp_a || a2d_done !== exp_a || timeout_err !== exp_to ||
          inert_rd !== m_inert_rd || a2d_rd !== m_a2d_rd || inert_gnt !== !exp_a || a2d_gnt !== exp_a) begin
         n_fail++;
         $display("FAIL resp: early=%b idone=%b adone=%b tout=%b ird=%h ard=%h ig=%b ag=%b, want early=0 %b %b %b %h %h %b %b",
                  early, inert_done, a2d_done, timeout_err, inert_rd, a2d_rd, inert_gnt, a2d_gnt,
                  !exp_a, exp_a, exp_to, m_inert_rd, m_a2d_rd, !exp_a, exp_a);
      end
      tick();
      n_tests++;
      if (inert_gnt !== 1'b0 || a2d_gnt !== 1'b0 || inert_done !== 1'b0 || a2d_done !== 1'b0 ||
          timeout_err !== 1'b0 || inert_rd !== m_inert_rd || a2d_rd !== m_a2d_rd) begin
         n_fail++;
         $display("FAIL release: ig=%b ag=%b idone=%b adone=%b tout=%b ird=%h ard=%h, want 0 0 0 0 0 %h %h",
                  inert_gnt, a2d_gnt, inert_done, a2d_done, timeout_err, inert_rd, a2d_rd,
                  m_inert_rd, m_a2d_rd);
      end
   endtask

   task automatic check_all_zero(input string name);
      n_tests++;
      if (inert_gnt !== 1'b0 || a2d_gnt !== 1'b0 || inert_done !== 1'b0 || a2d_done !== 1'b0 ||
          spi_wrt !== 1'b0 || timeout_err !== 1'b0 || spi_cmd !== 16'h0 ||
          inert_rd !== 16'h0 || a2d_rd !== 16'h0) begin
         n_fail++;
         $display("FAIL %s: ig=%b ag=%b idone=%b adone=%b wrt=%b tout=%b cmd=%h ird=%h ard=%h, want all 0",
                  name, inert_gnt, a2d_gnt, inert_done, a2d_done, spi_wrt, timeout_err,
                  spi_cmd, inert_rd, a2d_rd);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; inert_req = 1'b1; a2d_req = 1'b1;
      tick(); tick();
      rst = 1'b0; inert_req = 1'b0; a2d_req = 1'b0;
      check_all_zero("reset");
      streak = 0; m_inert_rd = '0; m_a2d_rd = '0;
   endtask

   task automatic test_inert_only();
      bit o;
      inert_req = 1'b1; inert_cmd = 16'hA200;
      serve(18, 16'h1234, 1'b0, 1'b0, o);
      inert_req = 1'b0;
   endtask

   task automatic test_contention();
      bit o;
      logic [7:0] pat;
      pat = 8'b1000_1000;
      inert_req = 1'b1; a2d_req = 1'b1;
      for (int i = 0; i < 8; i++) begin
         inert_cmd = 16'($urandom); a2d_cmd = 16'($urandom);
         serve(int'($urandom_range(0, 3)), 16'($urandom), 1'b0, 1'b0, o);
         n_tests++;
         if (o !== pat[i]) begin
            n_fail++;
            $display("FAIL contention_order[%0d]: a2d_won=%b, want %b", i, o, pat[i]);
         end
      end
      inert_req = 1'b0; a2d_req = 1'b0;
      n_tests++;
      if (both_gnt_seen) begin
         n_fail++;
         $display("FAIL gnt_onehot: both grants seen high, want never");
      end
   endtask

   task automatic test_timeout();
      bit o;
      a2d_req = 1'b1; a2d_cmd = 16'h5A5A;
      serve(-1, 16'hDEAD, 1'b0, 1'b0, o);
      a2d_req = 1'b0;
   endtask

   task automatic test_tie();
      bit o;
      a2d_req = 1'b1; a2d_cmd = 16'h0F0F;
      serve(TO - 1, 16'h00FF, 1'b0, 1'b0, o);
      a2d_req = 1'b0;
   endtask

   task automatic test_stale_late();
      bit o;
      inert_req = 1'b1; inert_cmd = 16'h3C3C;
      serve(5, 16'hBEEF, 1'b1, 1'b1, o);
      inert_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit o;
      inert_req = 1'b1; inert_cmd = 16'h7777;
      repeat (4) tick();
      rst = 1'b1; inert_req = 1'b0;
      tick();
      rst = 1'b0;
      check_all_zero("reset_mid");
      streak = 0; m_inert_rd = '0; m_a2d_rd = '0;
      tick();
      check_all_zero("reset_mid_after");
      a2d_req = 1'b1; a2d_cmd = 16'h1111;
      serve(3, 16'h2222, 1'b0, 1'b0, o);
      a2d_req = 1'b0;
   endtask

   task automatic test_random();
      bit o;
      int k;
      for (int i = 0; i < 40; i++) begin
         inert_req = 1'($urandom_range(0, 1));
         a2d_req   = 1'($urandom_range(0, 1));
         if (!inert_req && !a2d_req) inert_req = 1'b1;
         inert_cmd = 16'($urandom); a2d_cmd = 16'($urandom);
         k = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
         serve(k, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, o);
      end
      inert_req = 1'b0; a2d_req = 1'b0;
      n_tests++;
      if (both_gnt_seen) begin
         n_fail++;
         $display("FAIL gnt_onehot_random: both grants seen high, want never");
      end
   endtask

   initial begin
      test_reset();
      test_inert_only();
      test_contention();
      test_timeout();
      test_tie();
      test_stale_late();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish, want finish");
      $fatal(1);
   end
endmodule
